n64_readcmd_tx: RTL

Console-side command transmitter for the N64 controller link. On a start request it serialises an 8-bit command (default 0x01, "read buttons") MSB-first onto the data line using N64 pulse-width coding, appends the console stop bit, then releases the line and opens a receive window for the controller-state receiver. It sits between the polling logic and the bidirectional data pad, and its receive-enable output gates the 4 MHz receiver.

---
 rtl/n64_pkg.sv | 29 ++
 rtl/n64_symbol_timer.sv | 27 ++
 rtl/n64_readcmd_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared constants for the N64 controller link
package n64_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BIT_LO  = 3'd1;
    localparam logic [2:0] ST_BIT_HI  = 3'd2;
    localparam logic [2:0] ST_STOP_LO = 3'd3;
    localparam logic [2:0] ST_STOP_HI = 3'd4;
    localparam logic [2:0] ST_RX_WAIT = 3'd5;

    localparam logic [7:0] N64_CMD_STATUS = 8'h00;
    localparam logic [7:0] N64_CMD_POLL   = 8'h01;
    localparam logic [7:0] N64_CMD_RESET  = 8'hFF;

    localparam int N64_US_CYC = 4;

    // Symbol durations in microseconds; a data bit's high time is the other of the pair.
    localparam int N64_BIT_LONG_US  = 3;
    localparam int N64_BIT_SHORT_US = 1;
    localparam int N64_STOP_LO_US   = 1;
    localparam int N64_STOP_HI_US   = 2;

    function automatic int n64_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/n64_symbol_timer.sv
// rtl/n64_symbol_timer.sv - loadable down-counter with expiry flag
module n64_symbol_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Loaded with duration-1, so a load at edge E is seen expired at edge E+duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/n64_readcmd_tx.sv
// rtl/n64_readcmd_tx.sv - N64 console command transmitter with receive window
module n64_readcmd_tx
    import n64_pkg::*;
#(
    parameter logic [7:0] CMD       = N64_CMD_POLL,
    parameter int          US_CYC    = N64_US_CYC,
    parameter int          RX_WINDOW = 600
) (
    input  logic clk_4M,
    input  logic rst_n,
    input  logic start,
    output logic dout,
    output logic busy,
    output logic rx_en,
    output logic done
);

    localparam int TW = $clog2(n64_max3(N64_BIT_LONG_US * US_CYC,
                                        N64_STOP_HI_US * US_CYC, RX_WINDOW));

    localparam logic [TW-1:0] T_SHORT   = TW'(N64_BIT_SHORT_US * US_CYC - 1);
    localparam logic [TW-1:0] T_LONG    = TW'(N64_BIT_LONG_US * US_CYC - 1);
    localparam logic [TW-1:0] T_STOP_LO = TW'(N64_STOP_LO_US * US_CYC - 1);
    localparam logic [TW-1:0] T_STOP_HI = TW'(N64_STOP_HI_US * US_CYC - 1);
    localparam logic [TW-1:0] T_RX      = TW'(RX_WINDOW - 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [2:0]    idx;
    logic [2:0]    idx_nx;
    logic [2:0]    idx_dec;
    logic [7:0]    cmd_bits;
    logic          start_q;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;

    assign cmd_bits = CMD;
    assign idx_dec  = idx - 3'd1;

    n64_symbol_timer #(.W(TW)) u_timer (
        .clk      (clk_4M),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start_q) begin
                    state_nx = ST_BIT_LO;
                    idx_nx   = 3'd7;
                    tmr_load = 1'b1;
                    tmr_val  = cmd_bits[7] ? T_SHORT : T_LONG;
                end
            end
            ST_BIT_LO: begin
                if (tmr_exp) begin
                    state_nx = ST_BIT_HI;
                    tmr_load = 1'b1;
                    tmr_val  = cmd_bits[idx] ? T_LONG : T_SHORT;
                end
            end
            ST_BIT_HI: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (idx != 3'd0) begin
                        state_nx = ST_BIT_LO;
                        idx_nx   = idx_dec;
                        tmr_val  = cmd_bits[idx_dec] ? T_SHORT : T_LONG;
                    end else begin
                        state_nx = ST_STOP_LO;
                        tmr_val  = T_STOP_LO;
                    end
                end
            end
            ST_STOP_LO: begin
                if (tmr_exp) begin
                    state_nx = ST_STOP_HI;
                    tmr_load = 1'b1;
                    tmr_val  = T_STOP_HI;
                end
            end
            ST_STOP_HI: begin
                if (tmr_exp) begin
                    state_nx = ST_RX_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = T_RX;
                end
            end
            ST_RX_WAIT: begin
                if (tmr_exp) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // start is captured only in IDLE and acted on one cycle later; outputs follow state_nx.
    always_ff @(posedge clk_4M or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 3'd7;
            start_q <= 1'b0;
            dout    <= 1'b1;
            busy    <= 1'b0;
            rx_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            start_q <= start && (state == ST_IDLE) && !start_q;
            dout    <= !((state_nx == ST_BIT_LO) || (state_nx == ST_STOP_LO));
            busy    <= (state_nx != ST_IDLE);
            rx_en   <= (state_nx == ST_RX_WAIT);
            done    <= (state == ST_RX_WAIT) && (state_nx == ST_IDLE);
        end
    end

endmodule
